button_debouncer: RTL

- Upstream conditioning stage for the operand/opcode load registers.
- Takes a raw, bouncing, asynchronous push-button signal and synchronises it to clk.
- Filters contact bounce with a consecutive-sample counter.
- Produces:
  - a clean debounced level;
  - a single-cycle press strobe, which drives the registers' load-enable input;
  - a single-cycle release strobe;
  - a wrapping press counter for debug LEDs.

---
 rtl/button_debouncer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_debouncer
// Conditions a raw, bouncing, asynchronous push-button for the operand/opcode
// load registers. The button is synchronised to clk with a two-flop
// synchroniser. A four-state FSM then filters contact bounce: a level change
// is accepted only after the synchronised input has stayed at the new value
// for DEBOUNCE_CYCLES consecutive samples while in a WAIT_* state.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   btn_in       in   raw push-button, asynchronous to clk, may bounce
//   btn_level    out  debounced, registered button level
//   btn_pulse    out  one-cycle strobe on an accepted press (0->1)
//   btn_release  out  one-cycle strobe on an accepted release (1->0)
//   press_count  out  accepted presses modulo 2^PCNT_W (wraps silently)
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    output logic              btn_level,
    output logic              btn_pulse,
    output logic              btn_release,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Terminal value of the qualification counter; the counter never passes it.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_cnt_done;
    logic              w_pulse_nxt;
    logic              w_release_nxt;
    logic              w_level_nxt;
    logic              r_level;
    logic              r_pulse;
    logic              r_release;
    logic [PCNT_W-1:0] r_press_cnt;

    assign w_cnt_done = (r_cnt == LP_CNT_LAST);

    // Two-flop synchroniser; only r_sync2 is seen by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state and qualification counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = {CNT_W{1'b0}};
        w_pulse_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_HIGH;
                end else begin
                    w_state_nxt = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync2) begin
                    // Bounce back to low: glitch rejected without a strobe.
                    w_state_nxt = IDLE_LOW;
                end else if (w_cnt_done) begin
                    w_state_nxt = PRESSED;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LOW;
                end else begin
                    w_state_nxt = PRESSED;
                end
            end
            WAIT_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                end else if (w_cnt_done) begin
                    w_state_nxt   = IDLE_LOW;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
            end
        endcase
    end

    // Level follows the state being entered so it changes on the same edge
    // as the strobe rather than one cycle later.
    assign w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == WAIT_LOW);

    // Registered outputs and wrapping press counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level     <= 1'b0;
            r_pulse     <= 1'b0;
            r_release   <= 1'b0;
            r_press_cnt <= {PCNT_W{1'b0}};
        end else begin
            r_level   <= w_level_nxt;
            r_pulse   <= w_pulse_nxt;
            r_release <= w_release_nxt;
            if (w_pulse_nxt) begin
                r_press_cnt <= r_press_cnt + PCNT_W'(1);
            end else begin
                r_press_cnt <= r_press_cnt;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_pulse   = r_pulse;
    assign btn_release = r_release;
    assign press_count = r_press_cnt;

endmodule
